// File: rtl/aidc_lite_ahb_mem_slave_if.sv
// rtl/aidc_lite_ahb_mem_slave_if.sv - AHB2 slave bus plus SRAM port bundle
interface aidc_lite_ahb_mem_slave_if #(
  parameter int ADDR_W = 10
);
  logic              hsel_i;
  logic [31:0]       haddr_i;
  logic [1:0]        htrans_i;
  logic              hwrite_i;
  logic [2:0]        hsize_i;
  logic [2:0]        hburst_i;
  logic [31:0]       hwdata_i;
  logic              hready_i;
  logic              hready_o;
  logic [1:0]        hresp_o;
  logic [31:0]       hrdata_o;
  logic              mem_cs_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hwdata_i, hready_i,
    input  mem_rdata_i,
    output hready_o, hresp_o, hrdata_o,
    output mem_cs_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hwdata_i, hready_i,
    output mem_rdata_i,
    input  hready_o, hresp_o, hrdata_o,
    input  mem_cs_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/aidc_lite_ahb_mem_slave.sv
// rtl/aidc_lite_ahb_mem_slave.sv - AHB2 slave backing bursts with a single-port 32-bit SRAM
module aidc_lite_ahb_mem_slave #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  aidc_lite_ahb_mem_slave_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_DEFER, S_DATA, S_ERR1, S_ERR2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;
  logic              dp_write;
  logic [ADDR_W-1:0] dp_addr;
  logic [3:0]        dp_be;
  logic              rd_pend;
  logic [31:0]       rd_hold;

  logic [31:0]       offset;
  logic              range_ok, size_ok, align_ok, acc_err;
  logic              slave_rdy, accept;
  logic [ADDR_W-1:0] acc_addr;
  logic [3:0]        acc_be;
  logic              wr_strobe, rd_now, rd_defer, rd_strobe;
  logic              unused_bits;

  // Offsets below BASE_ADDR wrap to huge values and fail the range test.
  assign offset   = bus.haddr_i - BASE_ADDR;
  assign range_ok = (offset[31:ADDR_W+2] == '0);
  assign acc_addr = offset[ADDR_W+1:2];

  always_comb begin
    size_ok  = 1'b1;
    align_ok = 1'b1;
    acc_be   = 4'hF;
    case (bus.hsize_i)
      3'b000: acc_be = 4'b0001 << bus.haddr_i[1:0];
      3'b001: begin
        acc_be   = 4'b0011 << bus.haddr_i[1:0];
        align_ok = ~bus.haddr_i[0];
      end
      3'b010: align_ok = (bus.haddr_i[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end

  assign acc_err   = ~(range_ok & size_ok & align_ok);
  assign slave_rdy = (state == S_IDLE) | (state == S_DATA) | (state == S_ERR2);
  assign accept    = ~rst & slave_rdy & bus.hsel_i & bus.hready_i & bus.htrans_i[1];

  // A completing write owns the SRAM; a read accepted alongside it is pushed one cycle.
  assign wr_strobe = ~rst & (state == S_DATA) & dp_write;
  assign rd_now    = accept & ~bus.hwrite_i & ~acc_err & ~wr_strobe;
  assign rd_defer  = accept & ~bus.hwrite_i & ~acc_err & wr_strobe;
  assign rd_strobe = rd_now | (~rst & (state == S_RD_DEFER));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_nxt = S_DATA;
      end
      S_RD_DEFER: state_nxt = (wait_cnt != 4'd0) ? S_WAIT : S_DATA;
      S_ERR1:     state_nxt = S_ERR2;
      default: begin
        state_nxt = S_IDLE;
        if (accept) begin
          wait_cnt_nxt = WAIT_INIT;
          if (acc_err) begin
            state_nxt    = S_ERR1;
            wait_cnt_nxt = 4'd0;
          end else if (rd_defer) begin
            state_nxt = S_RD_DEFER;
          end else if (WAIT_INIT != 4'd0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_be    <= 4'h0;
      rd_pend  <= 1'b0;
      rd_hold  <= 32'h0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      rd_pend  <= rd_strobe;
      if (rd_pend) rd_hold <= bus.mem_rdata_i;
      if (accept) begin
        dp_write <= bus.hwrite_i & ~acc_err;
        dp_addr  <= acc_addr;
        dp_be    <= acc_be;
      end
    end
  end

  logic              mem_cs, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    if (wr_strobe) begin
      mem_cs    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = dp_addr;
      mem_be    = dp_be;
      mem_wdata = bus.hwdata_i;
    end else if (rd_now) begin
      mem_cs   = 1'b1;
      mem_addr = acc_addr;
    end else if (rd_strobe) begin
      mem_cs   = 1'b1;
      mem_addr = dp_addr;
    end
  end

  assign bus.mem_cs_o    = mem_cs;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_wdata_o = mem_wdata;

  assign bus.hready_o = slave_rdy;
  assign bus.hresp_o  = ((state == S_ERR1) | (state == S_ERR2)) ? 2'b01 : 2'b00;
  assign bus.hrdata_o = rd_pend ? bus.mem_rdata_i : rd_hold;

  assign unused_bits = ^{bus.hburst_i, offset[1:0]};
endmodule

// File: tb/tb_aidc_lite_ahb_mem_slave.sv
// tb/tb_aidc_lite_ahb_mem_slave.sv - directed bench for aidc_lite_ahb_mem_slave
module tb_aidc_lite_ahb_mem_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aidc_lite_ahb_mem_slave_if #(.ADDR_W(10)) b0 ();
  aidc_lite_ahb_mem_slave_if #(.ADDR_W(10)) b2 ();
  assign b0.hready_i = b0.hready_o;
  assign b2.hready_i = b2.hready_o;

  aidc_lite_ahb_mem_slave #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  aidc_lite_ahb_mem_slave #(.ADDR_W(10), .BASE_ADDR(32'h4000_0000), .WAIT_CYCLES(2))
    u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  logic [31:0] mem0 [1024];
  logic [31:0] mem2 [1024];
  int wr_cnt0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= 32'h0;
        mem2[i] <= 32'h0;
      end
      mem2[5] <= 32'hCAFE_F00D;
    end else begin
      if (b0.mem_cs_o) begin
        if (b0.mem_we_o) begin
          wr_cnt0 <= wr_cnt0 + 1;
          for (int k = 0; k < 4; k++)
            if (b0.mem_be_o[k]) mem0[b0.mem_addr_o][8*k +: 8] <= b0.mem_wdata_o[8*k +: 8];
        end else begin
          b0.mem_rdata_i <= mem0[b0.mem_addr_o];
        end
      end
      if (b2.mem_cs_o) begin
        if (b2.mem_we_o) begin
          for (int k = 0; k < 4; k++)
            if (b2.mem_be_o[k]) mem2[b2.mem_addr_o][8*k +: 8] <= b2.mem_wdata_o[8*k +: 8];
        end else begin
          b2.mem_rdata_i <= mem2[b2.mem_addr_o];
        end
      end
    end
  end

  typedef struct packed {
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        cs;
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obs_t;

  obs_t o;
  int   n_chk;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t obs(input bit u);
    obs_t x;
    if (u) x = '{b2.hready_o, b2.hresp_o, b2.hrdata_o, b2.mem_cs_o, b2.mem_we_o,
                 b2.mem_addr_o, b2.mem_be_o, b2.mem_wdata_o};
    else   x = '{b0.hready_o, b0.hresp_o, b0.hrdata_o, b0.mem_cs_o, b0.mem_we_o,
                 b0.mem_addr_o, b0.mem_be_o, b0.mem_wdata_o};
    return x;
  endfunction

  // {cs, we, be, addr}
  function automatic logic [15:0] strb(input obs_t x);
    return {x.cs, x.we, x.be, x.addr};
  endfunction

  // {hready, hresp, cs, we}
  function automatic logic [4:0] stat(input obs_t x);
    return {x.hready, x.hresp, x.cs, x.we};
  endfunction

  task automatic drv(input bit u, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    if (u) begin
      b2.hsel_i = tr[1]; b2.htrans_i = tr; b2.hwrite_i = wr; b2.hsize_i = sz;
      b2.haddr_i = a; b2.hwdata_i = wd; b2.hburst_i = 3'b000;
    end else begin
      b0.hsel_i = tr[1]; b0.htrans_i = tr; b0.hwrite_i = wr; b0.hsize_i = sz;
      b0.haddr_i = a; b0.hwdata_i = wd; b0.hburst_i = 3'b111;
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit u, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    nxt();
    drv(u, tr, wr, sz, a, wd);
    @(negedge clk);
    o = obs(u);
  endtask

  task automatic burst0(input bit wr, input logic [31:0] addr, input int ncyc);
    logic [9:0]  w0;
    logic [31:0] d;
    w0 = addr[11:2];
    for (int c = 0; c < ncyc; c++) begin
      d = (c > 0) ? 32'h1000_0000 + 32'(c - 1) : 32'h0;
      if (c < 16) cyc(0, (c == 0) ? 2'b10 : 2'b11, wr, 3'b010, addr + 32'(4 * c), d);
      else        cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, d);
      chk("burst_hready", {31'b0, o.hready}, 32'h1);
      if (wr) begin
        chk("burst_wr_strobe", strb(o), (c == 0) ? 16'h0 : {1'b1, 1'b1, 4'hF, 10'(w0 + 10'(c - 1))});
        if (c > 0) chk("burst_wdata", o.wdata, d);
      end else begin
        chk("burst_rd_strobe", strb(o), (c < 16) ? {1'b1, 1'b0, 4'h0, 10'(w0 + 10'(c))} : 16'h0);
        if (c > 0) chk("burst_rdata", o.hrdata, d);
      end
    end
  endtask

  task automatic err_seq(input bit u, input string tag, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a);
    cyc(u, 2'b10, wr, sz, a, 32'h0);
    chk({tag, "_acc"}, strb(o), 16'h0);
    cyc(u, 2'b00, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFFF);
    chk({tag, "_err1"}, stat(o), 5'b0_01_00);
    cyc(u, 2'b00, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFFF);
    chk({tag, "_err2"}, stat(o), 5'b1_01_00);
  endtask

  int n0;

  initial begin
    rst = 1'b1;
    drv(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    drv(1, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    repeat (3) nxt();
    @(negedge clk);
    o = obs(0);
    chk("rst_stat", stat(o), 5'b1_00_00);
    chk("rst_hrdata", o.hrdata, 32'h0);
    chk("rst_strobe", strb(o), 16'h0);
    chk("rst_wdata", o.wdata, 32'h0);
    o = obs(1);
    chk("rst_stat_w2", stat(o), 5'b1_00_00);
    nxt();
    rst = 1'b0;

    // INCR16 write then read back, no wait states
    n0 = wr_cnt0;
    burst0(1'b1, 32'h0000_0080, 17);
    nxt();
    chk("burst_wr_count", 32'(wr_cnt0 - n0), 32'd16);
    burst0(1'b0, 32'h0000_0080, 17);

    // write then read of the same word: read strobe deferred one cycle
    cyc(0, 2'b10, 1'b1, 3'b010, 32'h10, 32'h0);
    chk("defer_wacc", stat(o), 5'b1_00_00);
    cyc(0, 2'b10, 1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF);
    chk("defer_wstrobe", strb(o), {1'b1, 1'b1, 4'hF, 10'h004});
    chk("defer_wdata", o.wdata, 32'hDEAD_BEEF);
    cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("defer_wait", stat(o), 5'b0_00_10);
    chk("defer_rstrobe", strb(o), {1'b1, 1'b0, 4'h0, 10'h004});
    cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("defer_done", stat(o), 5'b1_00_00);
    chk("defer_rdata", o.hrdata, 32'hDEAD_BEEF);

    // last word of the window is in range
    cyc(0, 2'b10, 1'b0, 3'b010, 32'h0000_0FFC, 32'h0);
    chk("top_strobe", strb(o), {1'b1, 1'b0, 4'h0, 10'h3FF});
    cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("top_rdata", o.hrdata, 32'h0);

    // out-of-window read, then a read accepted during the second error cycle
    cyc(0, 2'b10, 1'b0, 3'b010, 32'h0000_1000, 32'h0);
    chk("oor_acc", strb(o), 16'h0);
    cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("oor_err1", stat(o), 5'b0_01_00);
    cyc(0, 2'b10, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("oor_err2_acc", stat(o), 5'b1_01_10);
    chk("oor_err2_strobe", strb(o), {1'b1, 1'b0, 4'h0, 10'h004});
    cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("oor_next_stat", stat(o), 5'b1_00_00);
    chk("oor_next_rdata", o.hrdata, 32'hDEAD_BEEF);

    err_seq(0, "err_half_mis", 1'b0, 3'b001, 32'h1);
    err_seq(0, "err_size", 1'b0, 3'b011, 32'h0);
    err_seq(0, "err_word_mis_wr", 1'b1, 3'b010, 32'h2);

    // byte and halfword writes on their lanes, then word read-back
    cyc(0, 2'b10, 1'b1, 3'b000, 32'h3, 32'h0);
    chk("byte_acc", strb(o), 16'h0);
    cyc(0, 2'b10, 1'b1, 3'b001, 32'h6, 32'hAB00_0000);
    chk("byte_strobe", strb(o), {1'b1, 1'b1, 4'b1000, 10'h000});
    chk("byte_wdata", o.wdata, 32'hAB00_0000);
    cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h1234_0000);
    chk("half_strobe", strb(o), {1'b1, 1'b1, 4'b1100, 10'h001});
    chk("half_wdata", o.wdata, 32'h1234_0000);
    cyc(0, 2'b10, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("rb0_strobe", strb(o), {1'b1, 1'b0, 4'h0, 10'h000});
    cyc(0, 2'b11, 1'b0, 3'b010, 32'h4, 32'h0);
    chk("rb0_rdata", o.hrdata, 32'hAB00_0000);
    cyc(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("rb1_rdata", o.hrdata, 32'h1234_0000);

    // two wait states, non-zero base
    cyc(1, 2'b10, 1'b0, 3'b010, 32'h4000_0014, 32'h0);
    chk("w2_rd_acc", stat(o), 5'b1_00_10);
    chk("w2_rd_strobe", strb(o), {1'b1, 1'b0, 4'h0, 10'h005});
    cyc(1, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("w2_rd_wait1", stat(o), 5'b0_00_00);
    cyc(1, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("w2_rd_wait2", stat(o), 5'b0_00_00);
    cyc(1, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("w2_rd_done", stat(o), 5'b1_00_00);
    chk("w2_rd_data", o.hrdata, 32'hCAFE_F00D);

    cyc(1, 2'b10, 1'b1, 3'b010, 32'h4000_0018, 32'h0);
    chk("w2_wr_acc", strb(o), 16'h0);
    cyc(1, 2'b00, 1'b0, 3'b010, 32'h0, 32'h5555_AAAA);
    chk("w2_wr_wait1", stat(o), 5'b0_00_00);
    cyc(1, 2'b00, 1'b0, 3'b010, 32'h0, 32'h5555_AAAA);
    chk("w2_wr_wait2", stat(o), 5'b0_00_00);
    cyc(1, 2'b00, 1'b0, 3'b010, 32'h0, 32'h5555_AAAA);
    chk("w2_wr_done", stat(o), 5'b1_00_11);
    chk("w2_wr_strobe", strb(o), {1'b1, 1'b1, 4'hF, 10'h006});
    chk("w2_wr_wdata", o.wdata, 32'h5555_AAAA);

    err_seq(1, "err_below_base", 1'b0, 3'b010, 32'h3FFF_FFFC);

    // reset in beat 7 of a 16-beat write: pending write dropped
    n0 = wr_cnt0;
    burst0(1'b1, 32'h0000_0200, 7);
    nxt();
    rst = 1'b1;
    drv(0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    nxt();
    @(negedge clk);
    o = obs(0);
    chk("midrst_stat", stat(o), 5'b1_00_00);
    chk("midrst_hrdata", o.hrdata, 32'h0);
    chk("midrst_strobe", strb(o), 16'h0);
    chk("midrst_wdata", o.wdata, 32'h0);
    nxt();
    rst = 1'b0;
    repeat (3) nxt();
    chk("midrst_wr_count", 32'(wr_cnt0 - n0), 32'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
